// File: rtl/prng_block_gen_if.sv
// Stream and control bundle for prng_block_gen: seeding/enable controls in,
// FWFT block stream and status out.
interface prng_block_gen_if #(
    parameter int OUTPUT_WIDTH = 256,
    parameter int BEAT_W       = 128,
    parameter int FIFO_DEPTH   = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic                    en;
    logic                    seed_load;
    logic [BEAT_W-1:0]       seed_i;
    logic                    inject_fault;
    logic                    ready_i;
    logic [OUTPUT_WIDTH-1:0] data_o;
    logic                    valid_o;
    logic [LEVEL_W-1:0]      fifo_level_o;
    logic                    health_fail_o;

    modport master (
        output en, seed_load, seed_i, inject_fault, ready_i,
        input  data_o, valid_o, fifo_level_o, health_fail_o
    );

    modport slave (
        input  en, seed_load, seed_i, inject_fault, ready_i,
        output data_o, valid_o, fifo_level_o, health_fail_o
    );
endinterface

// File: rtl/prng_block_gen.sv
// Multi-lane Galois-LFSR block generator: beats are packed into blocks, screened
// by a repeated-block health test and queued in a first-word-fall-through FIFO.
module prng_block_gen #(
    parameter int                    OUTPUT_WIDTH = 256,
    parameter int                    LFSR_WIDTH   = 32,
    parameter int                    NUM_LANES    = 4,
    parameter logic [LFSR_WIDTH-1:0] POLY         = 32'h80200003,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'hACE1ACE1,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    prng_block_gen_if.slave bus
);
    localparam int BEAT_W  = NUM_LANES * LFSR_WIDTH;
    localparam int BEATS   = OUTPUT_WIDTH / BEAT_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [BEAT_W-1:0] reset_lanes();
        logic [BEAT_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_LANES; k++)
            v[k*LFSR_WIDTH +: LFSR_WIDTH] = DEFAULT_SEED ^ LFSR_WIDTH'(k + 1);
        return v;
    endfunction

    localparam logic [BEAT_W-1:0] LANES_RST = reset_lanes();

    typedef enum logic {ST_RUN, ST_FAIL} state_t;
    state_t state_reg, state_next;

    logic [BEAT_W-1:0]       lanes_reg, lanes_next;
    logic [CNT_W-1:0]        beat_cnt_reg;
    logic [OUTPUT_WIDTH-1:0] asm_reg, block;
    logic [OUTPUT_WIDTH-1:0] prev_block_reg;
    logic                    prev_valid_reg;
    logic [OUTPUT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_W-1:0]      level_reg;
    logic fifo_full, fifo_empty;
    logic gen_fire, block_done, repeat_hit, push, pop, flush;

    assign fifo_full  = (level_reg == LEVEL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_reg == '0);

    // Seeding wins over stepping; an all-zero lane seed would lock the LFSR, so it becomes 1.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LFSR_WIDTH-1:0] cur, stepped, seed_raw, seed_fix;
            assign cur      = lanes_reg[gi*LFSR_WIDTH +: LFSR_WIDTH];
            assign stepped  = cur[0] ? ((cur >> 1) ^ POLY) : (cur >> 1);
            assign seed_raw = bus.seed_i[gi*LFSR_WIDTH +: LFSR_WIDTH];
            assign seed_fix = (seed_raw == '0) ? {{(LFSR_WIDTH-1){1'b0}}, 1'b1} : seed_raw;
            assign lanes_next[gi*LFSR_WIDTH +: LFSR_WIDTH] =
                bus.seed_load                     ? seed_fix :
                (gen_fire && !bus.inject_fault)   ? stepped  : cur;
        end
    endgenerate

    // Block as it would look with the current (pre-step) beat dropped into its slot.
    always_comb begin
        block = asm_reg;
        block[beat_cnt_reg*BEAT_W +: BEAT_W] = lanes_reg;
    end

    always_comb begin
        state_next = state_reg;
        gen_fire   = 1'b0;
        block_done = 1'b0;
        repeat_hit = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (bus.seed_load) begin
            flush      = 1'b1;
            state_next = ST_RUN;
        end else if (state_reg == ST_RUN) begin
            gen_fire   = bus.en && !fifo_full;
            block_done = gen_fire && (beat_cnt_reg == CNT_W'(BEATS - 1));
            repeat_hit = block_done && prev_valid_reg && (block == prev_block_reg);
            push       = block_done && !repeat_hit;
            pop        = !fifo_empty && bus.ready_i && !repeat_hit;
            if (repeat_hit) begin
                flush      = 1'b1;
                state_next = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            lanes_reg      <= LANES_RST;
            beat_cnt_reg   <= '0;
            asm_reg        <= '0;
            prev_block_reg <= '0;
            prev_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lanes_reg <= lanes_next;
            if (bus.seed_load) begin
                beat_cnt_reg   <= '0;
                asm_reg        <= '0;
                prev_valid_reg <= 1'b0;
            end else if (gen_fire) begin
                beat_cnt_reg <= block_done ? '0 : beat_cnt_reg + CNT_W'(1);
                asm_reg      <= block_done ? '0 : block;
                if (push) begin
                    prev_block_reg <= block;
                    prev_valid_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_W'(1);
                2'b01:   level_reg <= level_reg - LEVEL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage needs no reset: data_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= block;
    end

    assign bus.valid_o       = !fifo_empty;
    assign bus.data_o        = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign bus.fifo_level_o  = level_reg;
    assign bus.health_fail_o = (state_reg == ST_FAIL);
endmodule
